multicycle_ctrl: RTL and testbench

//  Control FSM that sequences a multi-cycle RV32I datapath built from the existing PC, register-file/ALU and memory blocks.

---
 rtl/mc_ctrl_pkg.sv | 100 ++++++++++
 rtl/alu_decoder.sv | 27 ++
 rtl/multicycle_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM: states,
// opcodes, datapath mux selects, ALU operation codes and small decode helpers.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH,
    JALRADR,
    JAL,
    LUI,
    ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    logic [2:0] imm;
    imm = IMM_I;
    case (op)
      OP_STORE:  imm = IMM_S;
      OP_BRANCH: imm = IMM_B;
      OP_JAL:    imm = IMM_J;
      OP_LUI:    imm = IMM_U;
      default:   imm = IMM_I;
    endcase
    return imm;
  endfunction

  // Signed/unsigned compares produce 1 when "less than", so blt-style
  // branches are taken on a non-zero result.
  function automatic logic [3:0] branch_alu(input logic [2:0] funct3);
    logic [3:0] ctl;
    case (funct3)
      3'b100, 3'b101: ctl = ALU_SLT;
      3'b110, 3'b111: ctl = ALU_SLTU;
      default:        ctl = ALU_SUB;
    endcase
    return ctl;
  endfunction

  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
    logic taken;
    case (funct3)
      3'b000, 3'b101, 3'b111: taken = zero;
      3'b001, 3'b100, 3'b110: taken = ~zero;
      default:                taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder for R-type and I-type ALU instructions.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      // addi has no subtract form, so funct7b5 only matters for R-type here
      3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_control = ALU_SLL;
      3'b010:  alu_control = ALU_SLT;
      3'b011:  alu_control = ALU_SLTU;
      3'b100:  alu_control = ALU_XOR;
      3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_control = ALU_OR;
      3'b111:  alu_control = ALU_AND;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM driving datapath selects and write enables.
// Define MC_PERF_COUNTER_EN to build the cycle and retired-instruction counters.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trigger,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [3:0]           ALUControl,
  output logic [2:0]           ImmSrc,
  output logic [2:0]           AddressingControl,
  output logic                 busy,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret_cnt
);

  state_t     state_q, state_d;
  logic [3:0] decoded_alu;
  logic       terminal;

  alu_decoder u_alu_decoder (
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (decoded_alu)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Instructions always finish in one of these states; run control is only
  // consulted here so an instruction in flight is never abandoned.
  assign terminal = (state_q == MEMWB) || (state_q == MEMWRITE) ||
                    (state_q == ALUWB) || (state_q == BRANCH);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trigger) state_d = FETCH;
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALRADR;
          OP_LUI:            state_d = LUI;
          default:           state_d = ILLEGAL;
        endcase
      end
      MEMADR:  state_d = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD: state_d = MEMWB;
      MEMWB, MEMWRITE, ALUWB, BRANCH:
               state_d = trigger ? FETCH : IDLE;
      EXECR, EXECI, JAL, LUI:
               state_d = ALUWB;
      JALRADR: state_d = JAL;
      ILLEGAL: state_d = ILLEGAL;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    PCWrite           = 1'b0;
    AdrSrc            = ADR_PC;
    IRWrite           = 1'b0;
    MemWrite          = 1'b0;
    RegWrite          = 1'b0;
    ResultSrc         = RES_ALUOUT;
    ALUSrcA           = SRCA_PC;
    ALUSrcB           = SRCB_RS2;
    ALUControl        = ALU_ADD;
    AddressingControl = 3'b000;
    case (state_q)
      FETCH: begin
        AdrSrc    = ADR_PC;
        IRWrite   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        PCWrite   = 1'b1;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR, JALRADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        AdrSrc            = ADR_ALUOUT;
        AddressingControl = funct3;
      end
      MEMWB: begin
        ResultSrc         = RES_READDATA;
        RegWrite          = 1'b1;
        AddressingControl = funct3;
      end
      MEMWRITE: begin
        AdrSrc            = ADR_ALUOUT;
        MemWrite          = 1'b1;
        AddressingControl = funct3;
      end
      EXECR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = decoded_alu;
      end
      EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = decoded_alu;
      end
      ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ResultSrc  = RES_ALUOUT;
        ALUControl = branch_alu(funct3);
        PCWrite    = branch_taken(funct3, Zero);
      end
      // Target already sits in ALUOut (from DECODE or JALRADR); the ALU
      // meanwhile forms the link address for the following ALUWB.
      JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
      end
      LUI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = ALU_PASSB;
      end
      default: ;
    endcase
  end

  assign ImmSrc  = imm_src_of(op);
  assign busy    = (state_q != IDLE) && (state_q != ILLEGAL);
  assign illegal = (state_q == ILLEGAL);

`ifdef MC_PERF_COUNTER_EN
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_WIDTH-1:0] instret_cnt_q, instret_cnt_d;

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (busy) begin
      cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
    end
    if (terminal && ((state_d == FETCH) || (state_d == IDLE))) begin
      instret_cnt_d = instret_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  logic unused_terminal;
  assign unused_terminal = terminal;
  assign cycle_cnt       = '0;
  assign instret_cnt     = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and random instruction
// streams compared cycle by cycle against an instruction-level control model.
module tb_multicycle_ctrl;

  localparam int CW = 32;

  localparam int CL_LW   = 0;
  localparam int CL_SW   = 1;
  localparam int CL_R    = 2;
  localparam int CL_I    = 3;
  localparam int CL_BR   = 4;
  localparam int CL_JAL  = 5;
  localparam int CL_JALR = 6;
  localparam int CL_LUI  = 7;
  localparam int CL_ILL  = 8;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       irw;
    logic       memw;
    logic       regw;
    logic [1:0] rsrc;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [3:0] aluc;
    logic [2:0] imm;
    logic [2:0] addr;
    logic       busy;
    logic       ill;
  } ctrl_t;

  logic          clk, rst, trigger, funct7b5, Zero;
  logic [6:0]    op;
  logic [2:0]    funct3;
  logic          PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, busy, illegal;
  logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB;
  logic [3:0]    ALUControl;
  logic [2:0]    ImmSrc, AddressingControl;
  logic [CW-1:0] cycle_cnt, instret_cnt;
  ctrl_t         obs;

  int checks = 0;
  int errors = 0;
  int unsigned cyc_m = 0;
  int unsigned ins_m = 0;

  multicycle_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .AddressingControl(AddressingControl),
    .busy(busy), .illegal(illegal), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  assign obs = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ALUControl, ImmSrc, AddressingControl, busy, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] cls_op(input int cls);
    case (cls)
      CL_LW:   return 7'b0000011;
      CL_SW:   return 7'b0100011;
      CL_R:    return 7'b0110011;
      CL_I:    return 7'b0010011;
      CL_BR:   return 7'b1100011;
      CL_JAL:  return 7'b1101111;
      CL_JALR: return 7'b1100111;
      CL_LUI:  return 7'b0110111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Cycles per instruction including FETCH; an illegal op is seen for two.
  function automatic int latency(input int cls);
    case (cls)
      CL_LW, CL_JALR: return 5;
      CL_BR:          return 3;
      CL_ILL:         return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [2:0] ref_imm(input int cls);
    case (cls)
      CL_SW:   return 3'd1;
      CL_BR:   return 3'd2;
      CL_JAL:  return 3'd3;
      CL_LUI:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // ALU codes: ADD0 SUB1 AND2 OR3 XOR4 SLT5 SLTU6 SLL7 SRL8 SRA9 PASSB10
  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic f7, input bit is_r);
    case (f3)
      3'd0:    return (is_r && f7) ? 4'd1 : 4'd0;
      3'd1:    return 4'd7;
      3'd2:    return 4'd5;
      3'd3:    return 4'd6;
      3'd4:    return 4'd4;
      3'd5:    return f7 ? 4'd9 : 4'd8;
      3'd6:    return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic [3:0] ref_br_alu(input logic [2:0] f3);
    if (f3 == 3'd4 || f3 == 3'd5) return 4'd5;
    if (f3 == 3'd6 || f3 == 3'd7) return 4'd6;
    return 4'd1;
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic z);
    case (f3)
      3'd0:    return z;   // beq
      3'd1:    return !z;  // bne
      3'd4:    return !z;  // blt
      3'd5:    return z;   // bge
      3'd6:    return !z;  // bltu
      3'd7:    return z;   // bgeu
      default: return 1'b0;
    endcase
  endfunction

  function automatic ctrl_t idle_ctrl(input int cls);
    ctrl_t e;
    e = '0;
    e.imm = ref_imm(cls);
    return e;
  endfunction

  function automatic ctrl_t exp_ctrl(input int cls, input int k, input logic [2:0] f3,
                                     input logic f7, input logic z);
    ctrl_t e;
    e = '0;
    e.busy = 1'b1;
    e.imm  = ref_imm(cls);
    if (k == 0) begin
      e.pcw = 1'b1; e.irw = 1'b1; e.rsrc = 2'd2; e.sb = 2'd2;
    end else if (k == 1) begin
      e.sa = 2'd1; e.sb = 2'd1;
    end else begin
      case (cls)
        CL_LW: begin
          if (k == 2) begin e.sa = 2'd2; e.sb = 2'd1; end
          else if (k == 3) begin e.adr = 1'b1; e.addr = f3; end
          else begin e.rsrc = 2'd1; e.regw = 1'b1; e.addr = f3; end
        end
        CL_SW: begin
          if (k == 2) begin e.sa = 2'd2; e.sb = 2'd1; end
          else begin e.adr = 1'b1; e.memw = 1'b1; e.addr = f3; end
        end
        CL_R: begin
          if (k == 2) begin e.sa = 2'd2; e.aluc = ref_alu(f3, f7, 1'b1); end
          else e.regw = 1'b1;
        end
        CL_I: begin
          if (k == 2) begin e.sa = 2'd2; e.sb = 2'd1; e.aluc = ref_alu(f3, f7, 1'b0); end
          else e.regw = 1'b1;
        end
        CL_BR: begin
          e.sa = 2'd2; e.aluc = ref_br_alu(f3); e.pcw = ref_taken(f3, z);
        end
        CL_JAL: begin
          if (k == 2) begin e.sa = 2'd1; e.sb = 2'd2; e.pcw = 1'b1; end
          else e.regw = 1'b1;
        end
        CL_JALR: begin
          if (k == 2) begin e.sa = 2'd2; e.sb = 2'd1; end
          else if (k == 3) begin e.sa = 2'd1; e.sb = 2'd2; e.pcw = 1'b1; end
          else e.regw = 1'b1;
        end
        CL_LUI: begin
          if (k == 2) begin e.sb = 2'd1; e.aluc = 4'd10; end
          else e.regw = 1'b1;
        end
        default: begin
          e.busy = 1'b0; e.ill = 1'b1;
        end
      endcase
    end
    return e;
  endfunction

  task automatic chk_ctrl(input ctrl_t exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: outputs got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input logic [CW-1:0] got, input logic [CW-1:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
`ifdef MC_PERF_COUNTER_EN
    chk_val(cycle_cnt, cyc_m, {tag, ".cycle_cnt"});
    chk_val(instret_cnt, ins_m, {tag, ".instret_cnt"});
`else
    chk_val(cycle_cnt, '0, {tag, ".cycle_cnt"});
    chk_val(instret_cnt, '0, {tag, ".instret_cnt"});
`endif
  endtask

  // Entered just after the edge into FETCH; returns just after the edge
  // that leaves the instruction (or right after an async reset at rst_at).
  task automatic run_instr(input int cls, input logic [2:0] f3, input logic f7,
                           input logic z, input int drop_at, input int rst_at,
                           input string tag);
    int lat;
    lat = latency(cls);
    op = cls_op(cls); funct3 = f3; funct7b5 = f7; Zero = z;
    for (int k = 0; k < lat; k++) begin
      if (k == drop_at) trigger = 1'b0;
      @(negedge clk);
      chk_ctrl(exp_ctrl(cls, k, f3, f7, z), $sformatf("%s.c%0d", tag, k));
      chk_cnt($sformatf("%s.c%0d", tag, k));
      if (k == rst_at) begin
        #1 rst = 1'b0;
        #1;
        cyc_m = 0; ins_m = 0;
        chk_ctrl(idle_ctrl(cls), {tag, ".async_rst"});
        chk_cnt({tag, ".async_rst"});
        return;
      end
      @(posedge clk); #1;
      cyc_m++;
      if (k == lat - 1 && cls != CL_ILL) ins_m++;
    end
    $display("instr %-10s op=%b f3=%0d f7b5=%0d zero=%0d lat=%0d", tag, cls_op(cls), f3, f7, z, lat);
  endtask

  logic [2:0] br_f3 [6];

  initial begin
    int cls;
    logic [2:0] f3;
    br_f3[0] = 3'd0; br_f3[1] = 3'd1; br_f3[2] = 3'd4;
    br_f3[3] = 3'd5; br_f3[4] = 3'd6; br_f3[5] = 3'd7;
    rst = 1'b0; trigger = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_ctrl('0, "reset");
    chk_cnt("reset");
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk_ctrl('0, "idle_no_trigger");
    trigger = 1'b1;
    @(posedge clk); #1;

    run_instr(CL_LW,   3'd2, 1'b0, 1'b0, -1, -1, "lw");
    run_instr(CL_SW,   3'd1, 1'b0, 1'b0, -1, -1, "sw");
    run_instr(CL_R,    3'd0, 1'b0, 1'b0, -1, -1, "add");
    run_instr(CL_R,    3'd0, 1'b1, 1'b0, -1, -1, "sub");
    run_instr(CL_I,    3'd0, 1'b1, 1'b0, -1, -1, "addi");
    run_instr(CL_BR,   3'd1, 1'b0, 1'b0, -1, -1, "bne_nz");
    run_instr(CL_BR,   3'd5, 1'b0, 1'b0, -1, -1, "bge_nz");
    run_instr(CL_BR,   3'd4, 1'b0, 1'b1, -1, -1, "blt_z");
    run_instr(CL_JALR, 3'd0, 1'b0, 1'b0, -1, -1, "jalr");
    run_instr(CL_JAL,  3'd0, 1'b0, 1'b0, -1, -1, "jal");
    run_instr(CL_LUI,  3'd0, 1'b0, 1'b0, -1, -1, "lui");

    for (int n = 0; n < 40; n++) begin
      cls = int'($urandom_range(0, 7));
      f3  = (cls == CL_BR) ? br_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      run_instr(cls, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1,
                $sformatf("rnd%0d", n));
    end

    // Run enable dropped mid-lw: the load finishes, then the FSM parks.
    run_instr(CL_LW, 3'd4, 1'b0, 1'b0, 2, -1, "lw_stop");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_ctrl(idle_ctrl(CL_LW), $sformatf("stopped%0d", i));
      chk_cnt($sformatf("stopped%0d", i));
    end
    trigger = 1'b1;
    @(posedge clk); #1;
    run_instr(CL_R, 3'd7, 1'b0, 1'b0, -1, -1, "and_restart");

    // Reset lands in MEMWRITE: outputs must clear without a clock edge.
    run_instr(CL_SW, 3'd2, 1'b0, 1'b0, -1, 3, "sw_rst");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    run_instr(CL_ILL, 3'd0, 1'b0, 1'b0, -1, -1, "ill");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_ctrl(exp_ctrl(CL_ILL, 2, 3'd0, 1'b0, 1'b0), $sformatf("ill_hold%0d", i));
      chk_cnt($sformatf("ill_hold%0d", i));
      @(posedge clk); #1;
    end

    trigger = 1'b0; op = 7'd0;
    rst = 1'b0;
    cyc_m = 0; ins_m = 0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk_ctrl('0, "ill_cleared");
    chk_cnt("ill_cleared");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
